cache_refill_wr: RTL and testbench

Write-side controller sitting directly upstream of the cache data banks. It merges two write sources onto the per-bank RAM write ports of one cache line: line refills returned by the memory interface, and byte-masked store hits from the core. Refills arrive as four 32-bit beats and are steered one beat per bank. Stores write a single bank with byte strobes. All bank-side outputs are registered.

---
 rtl/cache_refill_wr_if.sv | 55 +++++
 rtl/cache_refill_wr.sv | 132 +++++++++++++
 tb/tb_cache_refill_wr.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_wr_if.sv
// Bundle of refill, store and bank-write signals around cache_refill_wr.
// The fwd_* bypass signals exist only when CACHE_REFILL_BYPASS_EN is defined.
interface cache_refill_wr_if #(
  parameter int INDEX_AW   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4
);
  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int SW = DATA_WIDTH / 8;

  logic                           refill_req_i;
  logic [INDEX_AW-1:0]            refill_index_i;
  logic                           mem_rvalid_i;
  logic [DATA_WIDTH-1:0]          mem_rdata_i;
  logic                           mem_rerr_i;
  logic                           mem_rready_o;
  logic                           st_valid_i;
  logic                           st_ready_o;
  logic [INDEX_AW-1:0]            st_index_i;
  logic [BW-1:0]                  st_bank_i;
  logic [SW-1:0]                  st_strb_i;
  logic [DATA_WIDTH-1:0]          st_data_i;
  logic [INDEX_AW-1:0]            bank_index_o;
  logic [BANK_NUM*SW-1:0]         bank_wr_en_o;
  logic [BANK_NUM*DATA_WIDTH-1:0] bank_wr_data_o;
  logic                           refill_busy_o;
  logic                           refill_done_o;
  logic                           refill_err_o;
`ifdef CACHE_REFILL_BYPASS_EN
  logic                           fwd_valid_o;
  logic [BW-1:0]                  fwd_word_o;
  logic [DATA_WIDTH-1:0]          fwd_data_o;
`endif

  // Cache FSM / memory side
  modport master (
`ifdef CACHE_REFILL_BYPASS_EN
    input  fwd_valid_o, fwd_word_o, fwd_data_o,
`endif
    output refill_req_i, refill_index_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i,
           st_valid_i, st_index_i, st_bank_i, st_strb_i, st_data_i,
    input  mem_rready_o, st_ready_o, bank_index_o, bank_wr_en_o, bank_wr_data_o,
           refill_busy_o, refill_done_o, refill_err_o
  );

  modport slave (
`ifdef CACHE_REFILL_BYPASS_EN
    output fwd_valid_o, fwd_word_o, fwd_data_o,
`endif
    input  refill_req_i, refill_index_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i,
           st_valid_i, st_index_i, st_bank_i, st_strb_i, st_data_i,
    output mem_rready_o, st_ready_o, bank_index_o, bank_wr_en_o, bank_wr_data_o,
           refill_busy_o, refill_done_o, refill_err_o
  );
endinterface

// File: rtl/cache_refill_wr.sv
// Merges line refills and byte-masked store hits onto the cache bank write ports.
// Optional refill-beat bypass outputs are enabled by defining CACHE_REFILL_BYPASS_EN.
module cache_refill_wr #(
  parameter int INDEX_AW   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 4
) (
  input logic              clk,
  input logic              rst_n,
  cache_refill_wr_if.slave bus
);
  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t                         state_q, state_d;
  logic [BW-1:0]                  beat_cnt_q;
  logic [INDEX_AW-1:0]            refill_idx_q;
  logic                           err_q;
  logic                           st_fire, refill_start, beat_fire, beat_ok, beat_err, last_beat;
  logic [INDEX_AW-1:0]            index_d, index_q;
  logic [BANK_NUM*SW-1:0]         wr_en_d, wr_en_q;
  logic [BANK_NUM*DATA_WIDTH-1:0] data_d, data_q;

  // Stores win over a pending refill request while idle
  assign st_fire      = (state_q == IDLE) && bus.st_valid_i;
  assign refill_start = (state_q == IDLE) && !bus.st_valid_i && bus.refill_req_i;
  assign beat_fire    = (state_q == REFILL) && bus.mem_rvalid_i;
  assign beat_ok      = beat_fire && !bus.mem_rerr_i;
  assign beat_err     = beat_fire && bus.mem_rerr_i;
  assign last_beat    = (beat_cnt_q == BW'(BANK_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (refill_start) state_d = REFILL;
      REFILL:  if (beat_err || (beat_ok && last_beat)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.st_ready_o    = (state_q == IDLE);
    bus.mem_rready_o  = (state_q == REFILL);
    bus.refill_busy_o = (state_q != IDLE);
    bus.refill_done_o = (state_q == DONE);
    bus.refill_err_o  = (state_q == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      refill_idx_q <= '0;
      err_q        <= 1'b0;
    end else if (refill_start) begin
      beat_cnt_q   <= '0;
      refill_idx_q <= bus.refill_index_i;
      err_q        <= 1'b0;
    end else begin
      if (beat_ok)  beat_cnt_q <= beat_cnt_q + 1'b1;
      if (beat_err) err_q      <= 1'b1;
    end
  end

  // Data is replicated to every slice; only the strobes select the bank
  always_comb begin
    index_d = index_q;
    data_d  = data_q;
    wr_en_d = '0;
    if (st_fire) begin
      index_d = bus.st_index_i;
      for (int b = 0; b < BANK_NUM; b++) begin
        data_d[b*DATA_WIDTH +: DATA_WIDTH] = bus.st_data_i;
        if (bus.st_bank_i == BW'(b)) wr_en_d[b*SW +: SW] = bus.st_strb_i;
      end
    end else if (beat_ok) begin
      index_d = refill_idx_q;
      for (int b = 0; b < BANK_NUM; b++) begin
        data_d[b*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata_i;
        if (beat_cnt_q == BW'(b)) wr_en_d[b*SW +: SW] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      wr_en_q <= '0;
      data_q  <= '0;
    end else begin
      index_q <= index_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
    end
  end

  assign bus.bank_index_o   = index_q;
  assign bus.bank_wr_en_o   = wr_en_q;
  assign bus.bank_wr_data_o = data_q;

`ifdef CACHE_REFILL_BYPASS_EN
  logic                  fwd_valid_q;
  logic [BW-1:0]         fwd_word_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // Mirrors the bank write of each good refill beat in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_word_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= beat_ok;
      if (beat_ok) begin
        fwd_word_q <= beat_cnt_q;
        fwd_data_q <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.fwd_valid_o = fwd_valid_q;
  assign bus.fwd_word_o  = fwd_word_q;
  assign bus.fwd_data_o  = fwd_data_q;
`endif
endmodule

// File: tb/tb_cache_refill_wr.sv
// Directed self-checking bench for cache_refill_wr with a behavioural byte-enabled bank model.
module tb_cache_refill_wr;
  localparam int INDEX_AW   = 8;
  localparam int DATA_WIDTH = 32;
  localparam int BANK_NUM   = 4;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  logic [31:0] ram [BANK_NUM][256];

  cache_refill_wr_if #(.INDEX_AW(INDEX_AW), .DATA_WIDTH(DATA_WIDTH), .BANK_NUM(BANK_NUM)) bus ();

  cache_refill_wr #(.INDEX_AW(INDEX_AW), .DATA_WIDTH(DATA_WIDTH), .BANK_NUM(BANK_NUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank RAMs capture strobed bytes at the end of the strobe cycle
  always @(posedge clk) begin
    for (int b = 0; b < BANK_NUM; b++)
      for (int k = 0; k < 4; k++)
        if (bus.bank_wr_en_o[b*4+k])
          ram[b][bus.bank_index_o][k*8 +: 8] <= bus.bank_wr_data_o[b*32 + k*8 +: 8];
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input logic [7:0] idx, input int bank, input logic [3:0] strb,
                         input logic [31:0] data, input logic [15:0] expEn, input string tag);
    bus.st_valid_i = 1'b1;
    bus.st_index_i = idx;
    bus.st_bank_i  = 2'(bank);
    bus.st_strb_i  = strb;
    bus.st_data_i  = data;
    @(negedge clk);
    checkOutput({tag, "_st_ready"}, 128'(bus.st_ready_o), 128'(1));
    checkOutput({tag, "_wr_en"}, 128'(bus.bank_wr_en_o), 128'(expEn));
    step();
  endtask

  task automatic refillCycle(input logic v, input logic [31:0] d, input logic e, input logic [7:0] idx,
                             inout logic [15:0] expEn, inout int written, input string tag);
    bus.mem_rvalid_i = v;
    bus.mem_rdata_i  = d;
    bus.mem_rerr_i   = e;
    @(negedge clk);
    checkOutput({tag, "_wr_en"}, 128'(bus.bank_wr_en_o), 128'(expEn));
    checkOutput({tag, "_rready"}, 128'(bus.mem_rready_o), 128'(1));
    checkOutput({tag, "_st_ready"}, 128'(bus.st_ready_o), 128'(0));
    checkOutput({tag, "_done"}, 128'(bus.refill_done_o), 128'(0));
    if (written > 0) checkOutput({tag, "_index"}, 128'(bus.bank_index_o), 128'(idx));
    step();
    if (v && !e) begin
      expEn = 16'hF << (4 * written);
      written++;
    end else begin
      expEn = 16'h0;
    end
  endtask

  // Full refill: beat i carries seed + i*0x11111111; errBeat >= BANK_NUM means no error
  task automatic applyStimulus(input logic [7:0] idx, input logic [31:0] seed, input int gap,
                               input int errBeat, input logic [15:0] expEn0, input string tag);
    logic [15:0] expEn;
    int          written;
    bus.refill_req_i   = 1'b1;
    bus.refill_index_i = idx;
    bus.mem_rvalid_i   = 1'b0;
    bus.mem_rerr_i     = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_c0_busy"}, 128'(bus.refill_busy_o), 128'(0));
    checkOutput({tag, "_c0_wr_en"}, 128'(bus.bank_wr_en_o), 128'(expEn0));
    step();
    expEn   = 16'h0;
    written = 0;
    for (int i = 0; i < BANK_NUM; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) refillCycle(1'b0, 32'h0, 1'b0, idx, expEn, written, tag);
      refillCycle(1'b1, seed + 32'h11111111 * i, (i == errBeat), idx, expEn, written, tag);
      if (i == errBeat) break;
    end
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rerr_i   = 1'b0;
    bus.refill_req_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done"}, 128'(bus.refill_done_o), 128'(1));
    checkOutput({tag, "_err"}, 128'(bus.refill_err_o), 128'(errBeat < BANK_NUM));
    checkOutput({tag, "_done_wr_en"}, 128'(bus.bank_wr_en_o), 128'(expEn));
    checkOutput({tag, "_done_rready"}, 128'(bus.mem_rready_o), 128'(0));
    checkOutput({tag, "_done_busy"}, 128'(bus.refill_busy_o), 128'(1));
    checkOutput({tag, "_done_st_ready"}, 128'(bus.st_ready_o), 128'(0));
    step();
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, 128'(bus.refill_busy_o), 128'(0));
    checkOutput({tag, "_idle_done"}, 128'(bus.refill_done_o), 128'(0));
    checkOutput({tag, "_idle_wr_en"}, 128'(bus.bank_wr_en_o), 128'(0));
    step();
    for (int b = 0; b < BANK_NUM; b++)
      if (b < errBeat)
        checkOutput($sformatf("%s_ram%0d", tag, b), 128'(ram[b][idx]), 128'(seed + 32'h11111111 * b));
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    bus.refill_req_i   = 1'b0;
    bus.refill_index_i = '0;
    bus.mem_rvalid_i   = 1'b0;
    bus.mem_rdata_i    = '0;
    bus.mem_rerr_i     = 1'b0;
    bus.st_valid_i     = 1'b0;
    bus.st_index_i     = '0;
    bus.st_bank_i      = '0;
    bus.st_strb_i      = '0;
    bus.st_data_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_en", 128'(bus.bank_wr_en_o), 128'(0));
    checkOutput("rst_index", 128'(bus.bank_index_o), 128'(0));
    checkOutput("rst_data", 128'(bus.bank_wr_data_o), 128'(0));
    checkOutput("rst_rready", 128'(bus.mem_rready_o), 128'(0));
    checkOutput("rst_busy", 128'(bus.refill_busy_o), 128'(0));
    checkOutput("rst_done", 128'(bus.refill_done_o), 128'(0));
    checkOutput("rst_err", 128'(bus.refill_err_o), 128'(0));
    checkOutput("rst_st_ready", 128'(bus.st_ready_o), 128'(1));
    rst_n = 1'b1;
    step();

    $display("[TB] store with byte strobes");
    doStore(8'h12, 2, 4'hF, 32'h01020304, 16'h0000, "pre");
    doStore(8'h12, 2, 4'h5, 32'hAABBCCDD, 16'h0F00, "st1");
    bus.st_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("st1_strobe", 128'(bus.bank_wr_en_o), 128'(16'h0500));
    checkOutput("st1_index", 128'(bus.bank_index_o), 128'(8'h12));
    checkOutput("st1_data", 128'(bus.bank_wr_data_o), {4{32'hAABBCCDD}});
    step();
    @(negedge clk);
    checkOutput("st1_idle_wr_en", 128'(bus.bank_wr_en_o), 128'(0));
    checkOutput("st1_ram", 128'(ram[2][8'h12]), 128'(32'h01BB03DD));
    step();

    $display("[TB] back-to-back refill beats");
    applyStimulus(8'h7F, 32'h11111111, 0, BANK_NUM, 16'h0, "fast");

    $display("[TB] refill with rvalid gaps");
    applyStimulus(8'h7E, 32'h50505050, 3, BANK_NUM, 16'h0, "gap");

    $display("[TB] bus error on beat 2");
    doStore(8'h40, 2, 4'hF, 32'hDEADBEEF, 16'h0000, "pre2");
    doStore(8'h40, 3, 4'hF, 32'hDEADBEEF, 16'h0F00, "pre3");
    bus.st_valid_i = 1'b0;
    applyStimulus(8'h40, 32'hA0A0A0A0, 0, 2, 16'hF000, "err");
    checkOutput("err_ram2_kept", 128'(ram[2][8'h40]), 128'(32'hDEADBEEF));
    checkOutput("err_ram3_kept", 128'(ram[3][8'h40]), 128'(32'hDEADBEEF));

    $display("[TB] store and refill request together");
    bus.refill_req_i   = 1'b1;
    bus.refill_index_i = 8'h30;
    doStore(8'h22, 1, 4'h3, 32'h55667788, 16'h0000, "both");
    bus.st_valid_i = 1'b0;
    applyStimulus(8'h30, 32'h0F0F0F0F, 0, BANK_NUM, 16'h0030, "both");
    checkOutput("both_st_ram", 128'(ram[1][8'h22][15:0]), 128'(16'h7788));

    $display("[TB] reset during refill");
    bus.refill_req_i   = 1'b1;
    bus.refill_index_i = 8'h55;
    step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE0000;
    step();
    bus.mem_rdata_i  = 32'hCAFE0001;
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.refill_req_i = 1'b0;
    @(negedge clk);
    checkOutput("rstm_pre_wr_en", 128'(bus.bank_wr_en_o), 128'(16'h00F0));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstm_wr_en", 128'(bus.bank_wr_en_o), 128'(0));
    checkOutput("rstm_busy", 128'(bus.refill_busy_o), 128'(0));
    checkOutput("rstm_st_ready", 128'(bus.st_ready_o), 128'(1));
    checkOutput("rstm_rready", 128'(bus.mem_rready_o), 128'(0));
    #1 rst_n = 1'b1;
    step();
    applyStimulus(8'h66, 32'h01010101, 0, BANK_NUM, 16'h0, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
